// File: rtl/adder48_arbiter.sv
// Round-robin arbiter sharing one 48+32-bit unsigned adder among NREQ requesters.
// Build option: define ADDER48_ARB_SAT_EN to saturate resp_sum[47:0] when the carry is set.
module adder48_arbiter #(
   parameter int NREQ = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*48-1:0]   req_a,
   input  logic [NREQ*32-1:0]   req_b,
   output logic [NREQ-1:0]      resp_valid,
   input  logic [NREQ-1:0]      resp_ready,
   output logic [48:0]          resp_sum,
   output logic                 busy
);

   localparam int GW = $clog2(NREQ);

   // Handshake: a transfer happens on the rising edge where valid and ready
   // are both high; ready is only ever asserted in IDLE, resp_valid only in RESP.
   typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

   state_t         state, state_nxt;
   logic [GW-1:0]  last_grant, grant_q, grant_c;
   logic           grant_found;
   logic [47:0]    a_q, sel_a;
   logic [31:0]    b_q, sel_b;
   logic [48:0]    raw_sum, sum_c;

   // Search starts one past the last served requester so priority rotates.
   always_comb begin : arb
      int            idx;
      logic [GW-1:0] idx_v;
      idx         = 0;
      idx_v       = '0;
      grant_c     = '0;
      grant_found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = int'(last_grant) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_v = GW'(idx);
         if (!grant_found && req_valid[idx_v]) begin
            grant_c     = idx_v;
            grant_found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_c == GW'(i)) begin
            sel_a = req_a[48*i +: 48];
            sel_b = req_b[32*i +: 32];
         end
      end
   end

   assign raw_sum = {1'b0, a_q} + {17'b0, b_q};

`ifdef ADDER48_ARB_SAT_EN
   assign sum_c = raw_sum[48] ? {1'b1, 48'hFFFF_FFFF_FFFF} : raw_sum;
`else
   assign sum_c = raw_sum;
`endif

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      resp_valid = '0;
      case (state)
         IDLE: begin
            if (grant_found) begin
               req_ready[grant_c] = rst_n;
               state_nxt          = CALC;
            end
         end
         CALC: state_nxt = RESP;
         RESP: begin
            resp_valid[grant_q] = 1'b1;
            if (resp_ready[grant_q]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         grant_q    <= '0;
         last_grant <= GW'(NREQ - 1);
         resp_sum   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && grant_found) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            grant_q <= grant_c;
         end
         if (state == CALC) resp_sum <= sum_c;
         if (state == RESP && resp_ready[grant_q]) last_grant <= grant_q;
      end
   end

endmodule

// File: tb/tb_adder48_arbiter.sv
// Self-checking bench for adder48_arbiter: vector table, scoreboard queue and
// hand-written sequences for arbitration order, backpressure and mid-flight reset.
`timescale 1ns/1ps
module tb_adder48_arbiter;

   localparam int N = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid, req_ready, resp_valid, resp_ready;
   logic [N*48-1:0] req_a;
   logic [N*32-1:0] req_b;
   logic [48:0]    resp_sum;
   logic           busy;

   logic [3:0]     v4, r4, rv4, rr4;
   logic [4*48-1:0] a4;
   logic [4*32-1:0] b4;
   logic [48:0]    s4;
   logic           busy4;

   int             n_checks = 0;
   int             n_errors = 0;
   logic [50:0]    exp_q[$];
   logic [50:0]    mon_e;

   typedef struct {
      logic [47:0] a;
      logic [31:0] b;
      logic [48:0] sum;
   } vec_t;
   vec_t tbl[8];

   adder48_arbiter #(.NREQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_sum(resp_sum), .busy(busy)
   );

   adder48_arbiter #(.NREQ(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .req_valid(v4), .req_ready(r4),
      .req_a(a4), .req_b(b4), .resp_valid(rv4), .resp_ready(rr4),
      .resp_sum(s4), .busy(busy4)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [48:0] sat(input logic [48:0] s);
`ifdef ADDER48_ARB_SAT_EN
      if (s[48]) return {1'b1, 48'hFFFF_FFFF_FFFF};
`endif
      return s;
   endfunction

   function automatic logic [48:0] model(input logic [47:0] a, input logic [31:0] b);
      return sat({1'b0, a} + {17'b0, b});
   endfunction

   function automatic logic [N-1:0] onehot(input int i);
      return N'(1) << i;
   endfunction

   function automatic logic [47:0] op_a(input int i, input int k);
      return 48'h0010_0000 * 48'(i + 1) + 48'(k);
   endfunction

   function automatic logic [31:0] op_b(input int i, input int k);
      return 32'hFFFF_FFF0 + 32'(i * 4 + k);
   endfunction

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [47:0] a, input logic [31:0] b);
      req_a[48*i +: 48] = a;
      req_b[32*i +: 32] = b;
   endtask

   task automatic issue(input int idx, input logic [47:0] a, input logic [31:0] b,
                        input logic [48:0] exp_sum);
      logic got;
      got = 1'b0;
      set_ops(idx, a, b);
      req_valid[idx] = 1'b1;
      exp_q.push_back({2'(idx), exp_sum});
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (req_ready[idx]) begin
            got = 1'b1;
            break;
         end
      end
      check("accept_timeout", 64'(got), 64'd1);
      check("req_ready_onehot", 64'(req_ready), 64'(onehot(idx)));
      step();
      req_valid[idx] = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      check(name, 64'(done), 64'd1);
      step();
   endtask

   task automatic wait4_resp(input string name, input logic [3:0] exp_v, input logic [48:0] exp_s);
      logic got;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (rv4 != 4'b0) begin
            got = 1'b1;
            break;
         end
      end
      check({name, "_timeout"}, 64'(got), 64'd1);
      check({name, "_valid"}, 64'(rv4), 64'(exp_v));
      check({name, "_sum"}, 64'(s4), 64'(exp_s));
   endtask

   // scoreboard: pop on every response handshake of the NREQ=2 instance
   always @(negedge clk) begin
      if (rst_n && (resp_valid & resp_ready) != '0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_resp: resp_valid=%b sum=%0h with empty queue", resp_valid, resp_sum);
         end else begin
            mon_e = exp_q.pop_front();
            check("resp_onehot", 64'(resp_valid), 64'(onehot(int'(mon_e[50:49]))));
            check("resp_sum", 64'(resp_sum), 64'(mon_e[48:0]));
         end
      end
   end

   initial begin
      logic           got, quiet;
      int             cnt[2];
      int             seq;
      logic [N-1:0]   acc;
      logic [48:0]    bp0;

      tbl[0] = '{48'h0000_0000_0010, 32'h0000_0005, 49'h0_0000_0000_0015};
      tbl[1] = '{48'hFFFF_FFFF_FFFF, 32'h0000_0001, 49'h1_0000_0000_0000};
      tbl[2] = '{48'hFFFF_FFFF_FFFF, 32'hFFFF_FFFF, 49'h1_0000_FFFF_FFFE};
      tbl[3] = '{48'h0000_0000_0000, 32'h0000_0000, 49'h0_0000_0000_0000};
      tbl[4] = '{48'h0001_0000_0000, 32'hFFFF_FFFF, 49'h0_0001_FFFF_FFFF};
      tbl[5] = '{48'h1234_5678_9ABC, 32'h1111_1111, 49'h0_1234_6789_ABCD};
      tbl[6] = '{48'h8000_0000_0000, 32'h0000_0000, 49'h0_8000_0000_0000};
      tbl[7] = '{48'hFFFF_0000_0000, 32'hFFFF_FFFF, 49'h0_FFFF_FFFF_FFFF};

      req_valid = '0; resp_ready = '0; req_a = '0; req_b = '0;
      v4 = '0; rr4 = '1; a4 = '0; b4 = '0;

      // reset values
      repeat (3) @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_resp_sum", 64'(resp_sum), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst4_resp_valid", 64'(rv4), 64'd0);
      check("rst4_busy", 64'(busy4), 64'd0);
      rst_n = 1'b1;
      step();

      // single request and latency
      resp_ready = 2'b11;
      issue(0, 48'h0000_0000_0010, 32'h5, sat(49'h15));
      @(negedge clk);
      check("lat_calc_valid", 64'(resp_valid), 64'd0);
      check("lat_calc_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("lat_resp_valid", 64'(resp_valid), 64'b01);
      wait_idle("single_drain");

      // vector table, alternating requesters
      for (int i = 0; i < 8; i++) begin
         issue(i % 2, tbl[i].a, tbl[i].b, sat(tbl[i].sum));
         wait_idle("tbl_drain");
      end

      // simultaneous persistent requesters: grants 0,1,0,1
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 2; i++)
            exp_q.push_back({2'(i), model(op_a(i, k), op_b(i, k))});
      cnt[0] = 0; cnt[1] = 0; seq = 0;
      set_ops(0, op_a(0, 0), op_b(0, 0));
      set_ops(1, op_a(1, 0), op_b(1, 0));
      req_valid = 2'b11;
      for (int c = 0; c < 60 && (cnt[0] < 2 || cnt[1] < 2); c++) begin
         @(negedge clk);
         acc = req_valid & req_ready;
         if (acc != '0) begin
            check("sim_grant_order", 64'(acc), 64'(onehot(seq % 2)));
            seq++;
         end
         step();
         for (int i = 0; i < 2; i++) begin
            if (acc[i]) begin
               cnt[i]++;
               if (cnt[i] == 2) req_valid[i] = 1'b0;
               else set_ops(i, op_a(i, cnt[i]), op_b(i, cnt[i]));
            end
         end
      end
      check("sim_grant_count", 64'(seq), 64'd4);
      wait_idle("sim_drain");

      // backpressure on requester 0 while requester 1 waits
      resp_ready = 2'b00;
      set_ops(0, 48'hABCD_0000_1234, 32'h0000_4321);
      set_ops(1, 48'h0000_0F00_0000, 32'hFFFF_0000);
      bp0 = model(48'hABCD_0000_1234, 32'h0000_4321);
      exp_q.push_back({2'd0, bp0});
      exp_q.push_back({2'd1, model(48'h0000_0F00_0000, 32'hFFFF_0000)});
      req_valid = 2'b11;
      @(negedge clk);
      check("bp_grant0", 64'(req_ready), 64'b01);
      step();
      req_valid[0] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (resp_valid != '0) begin
            got = 1'b1;
            break;
         end
         check("bp_ready_calc", 64'(req_ready), 64'd0);
      end
      check("bp_resp_timeout", 64'(got), 64'd1);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) @(negedge clk);
         check("bp_valid_hold", 64'(resp_valid), 64'b01);
         check("bp_sum_hold", 64'(resp_sum), 64'(bp0));
         check("bp_ready_hold", 64'(req_ready), 64'd0);
      end
      step();
      resp_ready = 2'b11;
      @(negedge clk);
      @(negedge clk);
      check("bp_next_grant", 64'(req_ready), 64'b10);
      step();
      req_valid[1] = 1'b0;
      wait_idle("bp_drain");

      // reset during CALC discards the transaction and restores priority to 0
      issue(0, 48'h0000_0000_0100, 32'h1, sat(49'h101));
      wait_idle("pre_abort_drain");
      set_ops(1, 48'h0000_0000_5555, 32'h7);
      req_valid = 2'b10;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready[1]) begin
            got = 1'b1;
            break;
         end
      end
      check("abort_accept", 64'(got), 64'd1);
      step();
      req_valid = '0;
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid_busy", 64'(busy), 64'd0);
      check("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
      check("rst_mid_resp_sum", 64'(resp_sum), 64'd0);
      check("rst_mid_req_ready", 64'(req_ready), 64'd0);
      quiet = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (resp_valid != '0) quiet = 1'b0;
      end
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (resp_valid != '0) quiet = 1'b0;
      end
      check("rst_mid_no_resp", 64'(quiet), 64'd1);
      step();
      set_ops(0, 48'h0001_0000_0000, 32'hFFFF_FFFF);
      set_ops(1, 48'h0000_0000_0042, 32'h0000_0008);
      exp_q.push_back({2'd0, sat(49'h0_0001_FFFF_FFFF)});
      exp_q.push_back({2'd1, sat(49'h0_0000_0000_004A)});
      req_valid = 2'b11;
      @(negedge clk);
      check("post_rst_grant0", 64'(req_ready), 64'b01);
      step();
      req_valid[0] = 1'b0;
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (req_ready != '0) begin
            got = 1'b1;
            break;
         end
      end
      check("post_rst_grant1", 64'(req_ready), 64'b10);
      step();
      req_valid[1] = 1'b0;
      wait_idle("post_rst_drain");

      // NREQ=4: make last_grant=1, then 1 and 3 valid -> 3 first, then 1
      a4[48*1 +: 48] = 48'h100; b4[32*1 +: 32] = 32'h1;
      v4 = 4'b0010;
      @(negedge clk);
      check("n4_first_grant1", 64'(r4), 64'b0010);
      step();
      v4 = 4'b0000;
      wait4_resp("n4_r1", 4'b0010, 49'h101);
      step();
      a4[48*1 +: 48] = 48'h200; b4[32*1 +: 32] = 32'h2;
      a4[48*3 +: 48] = 48'h300; b4[32*3 +: 32] = 32'h3;
      v4 = 4'b1010;
      @(negedge clk);
      check("n4_grant3", 64'(r4), 64'b1000);
      step();
      v4[3] = 1'b0;
      wait4_resp("n4_r3", 4'b1000, 49'h303);
      @(negedge clk);
      check("n4_grant1", 64'(r4), 64'b0010);
      step();
      v4[1] = 1'b0;
      wait4_resp("n4_r1b", 4'b0010, 49'h202);
      step();

      check("queue_empty", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
